posit_decode_pipe: RTL and testbench

Parametrised, pipelined posit<N,ES> decoder: the streaming successor of the combinational posit8 decoder. Accepts one N-bit posit word per cycle on a valid/ready handshake. Emits sign, signed scale, hidden-bit significand and zero/NaR flags after a fixed two-cycle latency, with full backpressure. Sits between the operand input registers and the posit arithmetic datapath.

---
 rtl/posit_decode_pipe.sv | 115 +++++++++++
 tb/tb_posit_decode_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_decode_pipe.sv
// Two-stage pipelined posit<N,ES> decoder with valid/ready handshake.
// S1 captures sign/special flags/magnitude; S2 extracts regime, exponent and fraction.
module posit_decode_pipe #(
    parameter int unsigned N  = 8,
    parameter int unsigned ES = 0,
    localparam int unsigned FW = N - 3 - ES,
    localparam int unsigned SW = $clog2((N - 1) << ES) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_posit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sign,
    output logic [SW-1:0] out_scale,
    output logic [FW:0]   out_sig,
    output logic          out_zero,
    output logic          out_nar
);

    localparam logic [N-1:0] NAR_WORD = N'(1) << (N - 1);

    logic         s1_v;
    logic         s1_sign;
    logic         s1_zero;
    logic         s1_nar;
    logic [N-2:0] s1_mag;

    logic adv_c;
    logic take_c;

    assign adv_c    = !out_valid || out_ready;
    assign in_ready = !s1_v || adv_c;
    assign take_c   = in_valid && in_ready;

    // Stage 1: sign, special-value flags and absolute value (MSB of magnitude is always 0 for non-NaR)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_sign <= 1'b0;
            s1_zero <= 1'b0;
            s1_nar  <= 1'b0;
            s1_mag  <= '0;
        end else begin
            if (in_ready) begin
                s1_v <= in_valid;
            end
            if (take_c) begin
                s1_sign <= in_posit[N-1];
                s1_zero <= (in_posit == '0);
                s1_nar  <= (in_posit == NAR_WORD);
                s1_mag  <= (N-1)'(in_posit[N-1] ? -in_posit : in_posit);
            end
        end
    end

    logic          regime_c;
    logic          run_c;
    int            m_c;
    int            k_c;
    int            e_c;
    logic [N-2:0]  tail_c;
    logic [FW-1:0] frac_c;
    logic [SW-1:0] scale_c;
    logic [FW:0]   sig_c;

    // Stage 2 decode: measure the regime run, then strip run + terminator and slice e / fraction
    always_comb begin
        regime_c = s1_mag[N-2];
        run_c    = 1'b1;
        m_c      = 0;
        for (int i = int'(N) - 2; i >= 0; i--) begin
            if (run_c && (s1_mag[i] == regime_c)) begin
                m_c = m_c + 1;
            end else begin
                run_c = 1'b0;
            end
        end
        k_c     = regime_c ? (m_c - 1) : -m_c;
        tail_c  = s1_mag << (m_c + 1);
        e_c     = int'(tail_c >> (FW + 2));
        scale_c = SW'(k_c * int'(1 << ES) + e_c);
        frac_c  = FW'(tail_c >> 2);
        sig_c   = {1'b1, frac_c};
    end

    // Output stage: advances when empty or drained, otherwise holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_scale <= '0;
            out_sig   <= '0;
            out_zero  <= 1'b0;
            out_nar   <= 1'b0;
        end else if (adv_c) begin
            out_valid <= s1_v;
            if (s1_v) begin
                out_sign <= s1_sign;
                out_zero <= s1_zero;
                out_nar  <= s1_nar;
                if (s1_zero || s1_nar) begin
                    out_scale <= '0;
                    out_sig   <= '0;
                end else begin
                    out_scale <= scale_c;
                    out_sig   <= sig_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Bench for posit_decode_pipe: posit<8,0> and posit<16,1> instances driven in lockstep,
// checked against a bit-queue reference decoder and a pipeline occupancy model.
module tb_posit_decode_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  in8 = '0;
    logic [15:0] in16 = '0;

    logic        ir8, ov8, s8, z8, n8;
    logic [3:0]  sc8;
    logic [5:0]  sig8;
    logic        ir16, ov16, s16, z16, n16;
    logic [5:0]  sc16;
    logic [12:0] sig16;

    always #5 clk = ~clk;

    posit_decode_pipe #(.N(8), .ES(0)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8), .in_posit(in8),
        .out_valid(ov8), .out_ready(out_ready), .out_sign(s8), .out_scale(sc8),
        .out_sig(sig8), .out_zero(z8), .out_nar(n8)
    );

    posit_decode_pipe #(.N(16), .ES(1)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16), .in_posit(in16),
        .out_valid(ov16), .out_ready(out_ready), .out_sign(s16), .out_scale(sc16),
        .out_sig(sig16), .out_zero(z16), .out_nar(n16)
    );

    typedef struct {
        bit s;
        int scale;
        int sig;
        bit z;
        bit nar;
        int acc;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   a;
    bit   hold_pend = 0;
    logic [31:0] h_sc8, h_sig8, h_sc16, h_sig16;
    logic        h_s8, h_z8, h_n8;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    // Reference: walk the magnitude bits MSB-first as a queue, consuming regime, terminator, e, fraction
    function automatic exp_t model(input int unsigned x, input int n, input int es, input int acc);
        exp_t r;
        int unsigned mask, mag;
        bit q[$];
        bit rb;
        int m, k, e, frac, fw;
        fw = n - 3 - es;
        mask = (32'd1 << n) - 1;
        r.acc = acc;
        r.s = x[n-1];
        r.z = (x == 0);
        r.nar = (x == (32'd1 << (n - 1)));
        r.scale = 0;
        r.sig = 0;
        if (r.z || r.nar) return r;
        mag = r.s ? (((32'd1 << n) - x) & mask) : x;
        for (int i = n - 2; i >= 0; i--) q.push_back(mag[i]);
        rb = q[0];
        m = 0;
        while (q.size() > 0 && q[0] == rb) begin
            void'(q.pop_front());
            m++;
        end
        if (q.size() > 0) void'(q.pop_front());
        k = rb ? m - 1 : -m;
        e = 0;
        for (int j = 0; j < es; j++) e = e * 2 + ((q.size() > 0) ? int'(q.pop_front()) : 0);
        frac = 0;
        for (int j = 0; j < fw; j++) frac = frac * 2 + ((q.size() > 0) ? int'(q.pop_front()) : 0);
        r.scale = k * (1 << es) + e;
        r.sig = (1 << fw) | frac;
        return r;
    endfunction

    task automatic cmp_out(input string tag, input exp_t e, input logic s, input logic [31:0] sc,
                           input logic [31:0] sg, input logic z, input logic n);
        chk({tag, "_sign"}, 32'(s), 32'(e.s));
        chk({tag, "_scale"}, sc, e.scale);
        chk({tag, "_sig"}, sg, e.sig);
        chk({tag, "_zero"}, 32'(z), 32'(e.z));
        chk({tag, "_nar"}, 32'(n), 32'(e.nar));
    endtask

    // One cycle: drive at negedge, check handshake and scoreboard mid-phase, advance to next negedge
    task automatic step(input bit v, input logic [7:0] d8, input logic [15:0] d16,
                        input bit ordy, output bit acc);
        int occ;
        bit exp_ir, exp_ov;
        exp_t e;
        in_valid = v;
        in8 = d8;
        in16 = d16;
        out_ready = ordy;
        #1;
        occ = q8.size();
        exp_ir = !(occ == 2 && !ordy);
        exp_ov = (occ > 0) && (cyc - q8[0].acc >= 2);
        chk("in_ready8", 32'(ir8), 32'(exp_ir));
        chk("in_ready16", 32'(ir16), 32'(exp_ir));
        chk("out_valid8", 32'(ov8), 32'(exp_ov));
        chk("out_valid16", 32'(ov16), 32'(exp_ov));
        if (hold_pend) begin
            chk("hold_scale8", 32'($signed(sc8)), h_sc8);
            chk("hold_sig8", 32'(sig8), h_sig8);
            chk("hold_flags8", {29'd0, s8, z8, n8}, {29'd0, h_s8, h_z8, h_n8});
            chk("hold_scale16", 32'($signed(sc16)), h_sc16);
            chk("hold_sig16", 32'(sig16), h_sig16);
        end
        hold_pend = ov8 && !ordy;
        h_sc8 = 32'($signed(sc8));
        h_sig8 = 32'(sig8);
        h_s8 = s8;
        h_z8 = z8;
        h_n8 = n8;
        h_sc16 = 32'($signed(sc16));
        h_sig16 = 32'(sig16);
        if (ov8 && ordy) begin
            if (q8.size() == 0) chk("spurious8", 32'(1), 32'(0));
            else begin
                e = q8.pop_front();
                cmp_out("d8", e, s8, 32'($signed(sc8)), 32'(sig8), z8, n8);
            end
        end
        if (ov16 && ordy) begin
            if (q16.size() == 0) chk("spurious16", 32'(1), 32'(0));
            else begin
                e = q16.pop_front();
                cmp_out("d16", e, s16, 32'($signed(sc16)), 32'(sig16), z16, n16);
            end
        end
        acc = v && ir8;
        if (acc) begin
            q8.push_back(model(32'(d8), 8, 0, cyc));
            q16.push_back(model(32'(d16), 16, 1, cyc));
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic lit8(input string tag, input bit s, input int sc, input int sg, input bit z, input bit n);
        chk({tag, "_v"}, 32'(ov8), 32'(1));
        chk({tag, "_sign"}, 32'(s8), 32'(s));
        chk({tag, "_scale"}, 32'($signed(sc8)), sc);
        chk({tag, "_sig"}, 32'(sig8), sg);
        chk({tag, "_zn"}, {30'd0, z8, n8}, {30'd0, z, n});
    endtask

    task automatic lit16(input string tag, input int sc, input int sg);
        chk({tag, "_scale"}, 32'($signed(sc16)), sc);
        chk({tag, "_sig"}, 32'(sig16), sg);
    endtask

    task automatic drain();
        bit d;
        for (int i = 0; i < 20 && q8.size() > 0; i++) step(0, 8'h00, 16'h0000, 1, d);
        chk("drain8", 32'(q8.size()), 32'(0));
        chk("drain16", 32'(q16.size()), 32'(0));
    endtask

    initial begin
        logic [7:0] bp[5];
        int idx;

        // Reset state
        #2;
        chk("rst_ov", 32'(ov8), 32'(0));
        chk("rst_ir", 32'(ir8), 32'(1));
        chk("rst_data", {sc8, sig8, s8, z8, n8}, 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic stream, one word per cycle
        step(1, 8'h40, 16'h4000, 1, a);
        step(1, 8'h01, 16'h0001, 1, a);
        lit8("w40", 0, 0, 6'b100000, 0, 0);
        step(1, 8'h7F, 16'h7FFF, 1, a);
        lit8("w01", 0, -6, 6'b100000, 0, 0);
        step(1, 8'hC0, 16'hC000, 1, a);
        lit8("w7F", 0, 6, 6'b100000, 0, 0);
        step(0, 8'h00, 16'h0000, 1, a);
        lit8("wC0", 1, 0, 6'b100000, 0, 0);
        drain();

        // Specials, mid-fraction word and its negation; posit<16,1> boundary words
        step(1, 8'h00, 16'h0001, 1, a);
        step(1, 8'h80, 16'h7FFF, 1, a);
        lit8("zero", 0, 0, 0, 1, 0);
        lit16("p16_0001", -28, 13'h1000);
        step(1, 8'h5A, 16'h4800, 1, a);
        lit8("nar", 1, 0, 0, 0, 1);
        lit16("p16_7FFF", 28, 13'h1000);
        step(1, 8'hA6, 16'h0000, 1, a);
        lit8("w5A", 0, 0, 6'b111010, 0, 0);
        lit16("p16_4800", 0, 13'h1800);
        step(0, 8'h00, 16'h0000, 1, a);
        lit8("wA6", 1, 0, 6'b111010, 0, 0);
        drain();

        // Backpressure: 4 stalled cycles, then random out_ready until all 5 words are in
        bp = '{8'h40, 8'h5A, 8'h01, 8'hC3, 8'h7E};
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            step(1, bp[idx], 16'(bp[idx]) << 8, 0, a);
            if (a) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'(2));
        for (int i = 0; i < 100 && idx < 5; i++) begin
            step(1, bp[idx], 16'(bp[idx]) << 8, 1'($urandom_range(0, 1)), a);
            if (a) idx++;
        end
        chk("bp_all_sent", 32'(idx), 32'(5));
        drain();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), 16'($urandom),
                 $urandom_range(0, 3) != 0, a);
        end
        drain();

        // Asynchronous reset with two words in flight
        step(1, 8'h11, 16'h1234, 1, a);
        step(1, 8'h22, 16'h2345, 1, a);
        #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_ov8", 32'(ov8), 32'(0));
        chk("arst_ov16", 32'(ov16), 32'(0));
        chk("arst_ir", 32'(ir8), 32'(1));
        chk("arst_data", {sc8, sig8, s8, z8, n8}, 32'(0));
        q8.delete();
        q16.delete();
        hold_pend = 0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 16'h0000, 1, a);
        step(1, 8'h5A, 16'h4800, 1, a);
        chk("post_rst_acc", 32'(a), 32'(1));
        step(0, 8'h00, 16'h0000, 1, a);
        step(0, 8'h00, 16'h0000, 1, a);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
